// File: rtl/master_clk_gen.sv
// Multi-channel clock-enable / square-wave generator with a stretched synchronous
// reset for downstream blocks. One master_clk_gen_ch instance per divider channel.

module master_clk_gen_ch #(
    parameter int DIV_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr,
    input  logic                 sync,
    input  logic                 run,
    input  logic [DIV_WIDTH-1:0] wr_div,
    input  logic                 wr_en,
    output logic                 ce,
    output logic                 clk_out
);
    logic [DIV_WIDTH-1:0] div;
    logic [DIV_WIDTH-1:0] cnt;
    logic                 en;

    // Priority: reset > own config write > sync > count
    always_ff @(posedge clk) begin
        if (rst) begin
            div     <= '1;
            cnt     <= '0;
            en      <= 1'b0;
            ce      <= 1'b0;
            clk_out <= 1'b0;
        end else if (wr) begin
            div     <= wr_div;
            en      <= wr_en;
            cnt     <= wr_div;
            ce      <= 1'b0;
            clk_out <= 1'b0;
        end else if (sync) begin
            cnt     <= div;
            ce      <= 1'b0;
            clk_out <= 1'b0;
        end else if (en && run) begin
            // Reload at zero, so the counter never wraps below 0
            if (cnt == '0) begin
                cnt     <= div;
                ce      <= 1'b1;
                clk_out <= ~clk_out;
            end else begin
                cnt <= cnt - DIV_WIDTH'(1);
                ce  <= 1'b0;
            end
        end else begin
            ce <= 1'b0;
        end
    end
endmodule

module master_clk_gen #(
    parameter  int NUM_CH    = 4,
    parameter  int DIV_WIDTH = 8,
    parameter  int RST_HOLD  = 4,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                 master_clk,
    input  logic                 master_rst,
    input  logic                 cfg_we,
    input  logic [CH_W-1:0]      cfg_ch,
    input  logic [DIV_WIDTH-1:0] cfg_div,
    input  logic                 cfg_en,
    input  logic                 sync,
    output logic [NUM_CH-1:0]    ce,
    output logic [NUM_CH-1:0]    clk_out,
    output logic                 sys_rst_out
);
    typedef struct packed {
        logic                 we;
        logic [CH_W-1:0]      ch;
        logic [DIV_WIDTH-1:0] div;
        logic                 en;
    } cfg_req_t;

    cfg_req_t          req;
    logic [NUM_CH-1:0] wr_sel;
    logic [7:0]        hold_cnt;

    assign req = '{we: cfg_we, ch: cfg_ch, div: cfg_div, en: cfg_en};

    // Reset stretcher: sys_rst_out falls RST_HOLD+1 edges after master_rst drops
    always_ff @(posedge master_clk) begin
        if (master_rst) begin
            hold_cnt    <= 8'(RST_HOLD);
            sys_rst_out <= 1'b1;
        end else begin
            sys_rst_out <= (hold_cnt != 8'd0);
            hold_cnt    <= (hold_cnt == 8'd0) ? 8'd0 : hold_cnt - 8'd1;
        end
    end

    // Out-of-range channel indices decode to no channel at all
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign wr_sel[i] = req.we && (int'(req.ch) == i);

        master_clk_gen_ch #(.DIV_WIDTH(DIV_WIDTH)) u_ch (
            .clk     (master_clk),
            .rst     (master_rst),
            .wr      (wr_sel[i]),
            .sync    (sync),
            .run     (~sys_rst_out),
            .wr_div  (req.div),
            .wr_en   (req.en),
            .ce      (ce[i]),
            .clk_out (clk_out[i])
        );
    end
endmodule

// File: tb/tb_master_clk_gen.sv
// Scoreboard bench for master_clk_gen: expected ce/clk_out/sys_rst_out per cycle
// are derived from the edge-timing rules and queued before each scenario runs.

module tb_master_clk_gen;
    localparam int NUM_CH    = 5;
    localparam int DIV_WIDTH = 8;
    localparam int RST_HOLD  = 4;
    localparam int CH_W      = 3;

    logic                 master_clk = 1'b0;
    logic                 master_rst = 1'b1;
    logic                 cfg_we     = 1'b0;
    logic [CH_W-1:0]      cfg_ch     = '0;
    logic [DIV_WIDTH-1:0] cfg_div    = '0;
    logic                 cfg_en     = 1'b0;
    logic                 sync       = 1'b0;
    logic [NUM_CH-1:0]    ce;
    logic [NUM_CH-1:0]    clk_out;
    logic                 sys_rst_out;

    typedef struct {
        logic [NUM_CH-1:0] ce;
        logic [NUM_CH-1:0] co;
        logic [NUM_CH-1:0] mask;
        logic              sys;
        int                k;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    master_clk_gen #(.NUM_CH(NUM_CH), .DIV_WIDTH(DIV_WIDTH), .RST_HOLD(RST_HOLD)) dut (
        .master_clk  (master_clk),
        .master_rst  (master_rst),
        .cfg_we      (cfg_we),
        .cfg_ch      (cfg_ch),
        .cfg_div     (cfg_div),
        .cfg_en      (cfg_en),
        .sync        (sync),
        .ce          (ce),
        .clk_out     (clk_out),
        .sys_rst_out (sys_rst_out)
    );

    always #5 master_clk = ~master_clk;

    // Channel restarted (write or sync) at edge t0, observed after edge t0+k
    function automatic void wave(input int d, input int k, output logic ce_o, output logic co_o);
        ce_o = (k > 0) && ((k % (d + 1)) == 0);
        co_o = ((k / (d + 1)) % 2) == 1;
    endfunction

    task automatic write_cfg(input int ch, input int d, input logic en);
        cfg_we  = 1'b1;
        cfg_ch  = CH_W'(ch);
        cfg_div = DIV_WIDTH'(d);
        cfg_en  = en;
    endtask

    task automatic test_reset();
        exp_t e;
        for (int k = 0; k < 8; k++) begin
            e.ce = '0; e.co = '0; e.mask = '1; e.sys = (k <= RST_HOLD); e.k = k;
            sb.push_back(e);
        end
        master_rst = 1'b1;
        repeat (3) @(posedge master_clk);
        for (int k = 0; k < 8; k++) begin
            @(negedge master_clk);
            e = sb.pop_front();
            n_chk++;
            if ((ce & e.mask) !== (e.ce & e.mask) || (clk_out & e.mask) !== (e.co & e.mask) ||
                sys_rst_out !== e.sys) begin
                n_fail++;
                $display("FAIL reset k=%0d: got ce=%b clk_out=%b sys=%b, want ce=%b clk_out=%b sys=%b",
                         e.k, ce, clk_out, sys_rst_out, e.ce, e.co, e.sys);
            end
            master_rst = 1'b0;
        end
    endtask

    task automatic test_div3();
        exp_t e;
        for (int k = 0; k < 20; k++) begin
            e.ce = '0; e.co = '0; e.mask = 5'b00001; e.sys = 1'b0; e.k = k;
            wave(3, k, e.ce[0], e.co[0]);
            sb.push_back(e);
        end
        write_cfg(0, 3, 1'b1);
        for (int k = 0; k < 20; k++) begin
            @(negedge master_clk);
            e = sb.pop_front();
            n_chk++;
            if ((ce & e.mask) !== (e.ce & e.mask) || (clk_out & e.mask) !== (e.co & e.mask) ||
                sys_rst_out !== e.sys) begin
                n_fail++;
                $display("FAIL div3 k=%0d: got ce=%b clk_out=%b sys=%b, want ce=%b clk_out=%b sys=%b mask=%b",
                         e.k, ce, clk_out, sys_rst_out, e.ce, e.co, e.sys, e.mask);
            end
            cfg_we = 1'b0;
        end
    endtask

    task automatic test_extremes();
        exp_t e;
        // ch1 D=0 written at edge E, ch2 D=255 written at edge E+1
        for (int k = 0; k < 515; k++) begin
            e.ce = '0; e.co = '0; e.sys = 1'b0; e.k = k;
            e.mask = (k == 0) ? 5'b00010 : 5'b00110;
            wave(0, k, e.ce[1], e.co[1]);
            if (k > 0) wave(255, k - 1, e.ce[2], e.co[2]);
            sb.push_back(e);
        end
        write_cfg(1, 0, 1'b1);
        for (int k = 0; k < 515; k++) begin
            @(negedge master_clk);
            e = sb.pop_front();
            n_chk++;
            if ((ce & e.mask) !== (e.ce & e.mask) || (clk_out & e.mask) !== (e.co & e.mask) ||
                sys_rst_out !== e.sys) begin
                n_fail++;
                $display("FAIL extremes k=%0d: got ce=%b clk_out=%b sys=%b, want ce=%b clk_out=%b sys=%b mask=%b",
                         e.k, ce, clk_out, sys_rst_out, e.ce, e.co, e.sys, e.mask);
            end
            if (k == 0) write_cfg(2, 255, 1'b1);
            else        cfg_we = 1'b0;
        end
    endtask

    task automatic test_sync();
        exp_t e;
        int   ds[NUM_CH] = '{3, 0, 255, 2, 5};
        write_cfg(3, 2, 1'b1);
        @(negedge master_clk);
        write_cfg(4, 5, 1'b1);
        @(negedge master_clk);
        cfg_we = 1'b0;
        repeat (3) @(negedge master_clk);
        for (int k = 0; k < 25; k++) begin
            e.ce = '0; e.co = '0; e.mask = '1; e.sys = 1'b0; e.k = k;
            for (int c = 0; c < NUM_CH; c++) wave(ds[c], k, e.ce[c], e.co[c]);
            sb.push_back(e);
        end
        sync = 1'b1;
        for (int k = 0; k < 25; k++) begin
            @(negedge master_clk);
            e = sb.pop_front();
            n_chk++;
            if ((ce & e.mask) !== (e.ce & e.mask) || (clk_out & e.mask) !== (e.co & e.mask) ||
                sys_rst_out !== e.sys) begin
                n_fail++;
                $display("FAIL sync k=%0d: got ce=%b clk_out=%b sys=%b, want ce=%b clk_out=%b sys=%b",
                         e.k, ce, clk_out, sys_rst_out, e.ce, e.co, e.sys);
            end
            sync = 1'b0;
        end
    endtask

    // sync at k=0, disable ch3 at k=3, stray write to ch7 at k=5, sync+write ch4 at k=12
    task automatic test_corner();
        exp_t e;
        int   ds1[NUM_CH] = '{3, 0, 255, 2, 5};
        int   ds2[NUM_CH] = '{3, 0, 255, 2, 1};
        for (int k = 0; k < 28; k++) begin
            e.ce = '0; e.co = '0; e.mask = '1; e.sys = 1'b0; e.k = k;
            for (int c = 0; c < NUM_CH; c++) begin
                if (k < 12) wave(ds1[c], k, e.ce[c], e.co[c]);
                else        wave(ds2[c], k - 12, e.ce[c], e.co[c]);
            end
            if (k >= 3) begin
                e.ce[3] = 1'b0;
                e.co[3] = 1'b0;
            end
            sb.push_back(e);
        end
        sync = 1'b1;
        for (int k = 0; k < 28; k++) begin
            @(negedge master_clk);
            e = sb.pop_front();
            n_chk++;
            if ((ce & e.mask) !== (e.ce & e.mask) || (clk_out & e.mask) !== (e.co & e.mask) ||
                sys_rst_out !== e.sys) begin
                n_fail++;
                $display("FAIL corner k=%0d: got ce=%b clk_out=%b sys=%b, want ce=%b clk_out=%b sys=%b",
                         e.k, ce, clk_out, sys_rst_out, e.ce, e.co, e.sys);
            end
            sync   = (k + 1 == 12);
            cfg_we = 1'b0;
            if (k + 1 == 3)  write_cfg(3, 2, 1'b0);
            if (k + 1 == 5)  write_cfg(7, 0, 1'b1);
            if (k + 1 == 12) write_cfg(4, 1, 1'b1);
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        // reset held for two edges; a write to ch0 during reset must not stick
        for (int k = 0; k < 16; k++) begin
            e.ce = '0; e.co = '0; e.mask = '1; e.sys = (k <= RST_HOLD + 1); e.k = k;
            sb.push_back(e);
        end
        master_rst = 1'b1;
        write_cfg(0, 7, 1'b1);
        for (int k = 0; k < 16; k++) begin
            @(negedge master_clk);
            e = sb.pop_front();
            n_chk++;
            if ((ce & e.mask) !== (e.ce & e.mask) || (clk_out & e.mask) !== (e.co & e.mask) ||
                sys_rst_out !== e.sys) begin
                n_fail++;
                $display("FAIL reset_mid k=%0d: got ce=%b clk_out=%b sys=%b, want ce=%b clk_out=%b sys=%b",
                         e.k, ce, clk_out, sys_rst_out, e.ce, e.co, e.sys);
            end
            if (k == 1) begin
                master_rst = 1'b0;
                cfg_we     = 1'b0;
            end
        end
    endtask

    initial begin
        test_reset();
        test_div3();
        test_extremes();
        test_sync();
        test_corner();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete within 100000 time units");
        $fatal(1);
    end
endmodule
